// File: rtl/thermal_monitor_pkg.sv
// thermal_monitor_pkg: register map, FSM states and timing constants for the DTR sequencer.
package thermal_monitor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CONVERT,
        S_CAPTURE,
        S_ACCUM,
        S_WAIT
    } state_e;

    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_RAW    = 8'h08;
    localparam logic [7:0] ADDR_AVG    = 8'h0C;
    localparam logic [7:0] ADDR_THR_HI = 8'h10;
    localparam logic [7:0] ADDR_THR_LO = 8'h14;
    localparam logic [7:0] ADDR_STATUS = 8'h18;
    localparam logic [7:0] ADDR_COUNT  = 8'h1C;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_TRIG  = 1;
    localparam int ST_OVER    = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_CAPERR  = 2;

    localparam logic [7:0] THR_HI_RST = 8'hC0;
    localparam logic [7:0] THR_LO_RST = 8'hB0;

    localparam int START_CYCLES = 4;
    localparam int CAP_MIN      = 2;
    localparam int CAP_TIMEOUT  = 16;

endpackage

// File: rtl/thermal_monitor_dtr_code_sync.sv
// dtr_code_sync: two-flop synchronizer for the DTR code plus a one-cycle-apart match compare.
module dtr_code_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dtr_code,
    output logic [7:0] code,
    output logic       stable
);

    logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

    always_comb begin
        s1_d = dtr_code;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign code   = s2_q;
    assign stable = s2_q == s3_q;

endmodule

// File: rtl/thermal_monitor.sv
// thermal_monitor: periodic DTR conversion sequencer with de-glitched capture, averaging and hysteretic alarm.
module thermal_monitor
    import thermal_monitor_pkg::*;
#(
    parameter int CONV_CYCLES   = 1024,
    parameter int PERIOD_CYCLES = 1000000,
    parameter int AVG_LOG2      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        dtr_start,
    input  logic [7:0]  dtr_code,
    output logic        over_temp,
    output logic        sample_strobe
);

    localparam int CW = $clog2(PERIOD_CYCLES + 1);
    localparam int AW = 8 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, per_q, per_d;
    logic          en_q, en_d, pend_q, pend_d, err_q, err_d, ot_q, ot_d;
    logic          strobe_q, strobe_d, ack_q, ack_d;
    logic [7:0]    samp_q, samp_d, raw_q, raw_d, avg_q, avg_d, hi_q, hi_d, lo_q, lo_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [NW-1:0] n_q, n_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [7:0]    code;
    logic          stable;

    dtr_code_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .dtr_code (dtr_code),
        .code     (code),
        .stable   (stable)
    );

    logic          wr, rd, wr_ctrl, wr_status, wr_hi, wr_lo, go, busy;
    logic          cap_ok, cap_to, cap_done, consume, acc_stage, publish;
    logic [AW-1:0] sum;
    logic [7:0]    new_avg;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign wr        = bus_req && bus_we;
    assign rd        = bus_req && !bus_we;
    assign wr_ctrl   = wr && bus_addr == ADDR_CTRL;
    assign wr_status = wr && bus_addr == ADDR_STATUS;
    assign wr_hi     = wr && bus_addr == ADDR_THR_HI;
    assign wr_lo     = wr && bus_addr == ADDR_THR_LO;
    assign go        = en_q || pend_q;
    assign busy      = state_q != S_IDLE;
    assign unused_wdata = &{1'b0, bus_wdata[31:8]};

    // Accept only after the synchronizer has refilled since entering CAPTURE.
    assign cap_ok   = cnt_q >= CW'(CAP_MIN) && stable;
    assign cap_to   = !cap_ok && cnt_q == CW'(CAP_TIMEOUT - 1);
    assign cap_done = state_q == S_CAPTURE && (cap_ok || cap_to);

    assign acc_stage = state_q == S_ACCUM;
    assign publish   = acc_stage && n_q == N_LAST;
    assign sum       = acc_q + AW'(samp_q);
    assign new_avg   = 8'(sum >> AVG_LOG2);

    // per_q counts from the first start cycle so start-to-start spacing ignores capture length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        per_d   = per_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                per_d = '0;
                if (go) state_d = S_START;
            end
            S_START: if (cnt_q == CW'(START_CYCLES - 1)) begin
                state_d = S_CONVERT;
                cnt_d   = '0;
            end
            S_CONVERT: if (cnt_q == CW'(CONV_CYCLES - 1)) begin
                state_d = S_CAPTURE;
                cnt_d   = '0;
            end
            S_CAPTURE: if (cap_done) begin
                state_d = S_ACCUM;
                cnt_d   = '0;
            end
            S_ACCUM: begin
                state_d = go ? S_WAIT : S_IDLE;
                cnt_d   = '0;
            end
            S_WAIT: if (per_q == CW'(PERIOD_CYCLES - 1)) begin
                state_d = go ? S_START : S_IDLE;
                cnt_d   = '0;
                per_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign consume = (state_q == S_IDLE || state_q == S_WAIT) && state_d == S_START;

    assign rd_mux = bus_addr == ADDR_CTRL   ? {31'b0, en_q} :
                    bus_addr == ADDR_RAW    ? {24'b0, raw_q} :
                    bus_addr == ADDR_AVG    ? {24'b0, avg_q} :
                    bus_addr == ADDR_THR_HI ? {24'b0, hi_q} :
                    bus_addr == ADDR_THR_LO ? {24'b0, lo_q} :
                    bus_addr == ADDR_STATUS ? {29'b0, err_q, busy, ot_q} :
                    bus_addr == ADDR_COUNT  ? {16'b0, count_q} : 32'b0;

    always_comb begin
        pend_d   = wr_ctrl && bus_wdata[CTRL_TRIG] ? 1'b1 : consume ? 1'b0 : pend_q;
        en_d     = wr_ctrl ? bus_wdata[CTRL_EN] : en_q;
        hi_d     = wr_hi ? bus_wdata[7:0] : hi_q;
        lo_d     = wr_lo ? bus_wdata[7:0] : lo_q;
        err_d    = state_q == S_CAPTURE && cap_to ? 1'b1 :
                   wr_status && bus_wdata[ST_CAPERR] ? 1'b0 : err_q;
        samp_d   = cap_done ? code : samp_q;
        raw_d    = acc_stage ? samp_q : raw_q;
        acc_d    = publish ? '0 : acc_stage ? sum : acc_q;
        n_d      = publish ? '0 : acc_stage ? n_q + 1'b1 : n_q;
        avg_d    = publish ? new_avg : avg_q;
        count_d  = publish ? count_q + 16'd1 : count_q;
        strobe_d = publish;
        ot_d     = !publish ? ot_q : new_avg >= hi_q ? 1'b1 : new_avg < lo_q ? 1'b0 : ot_q;
        ack_d    = bus_req;
        rdata_d  = rd ? rd_mux : 32'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            per_q    <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            ot_q     <= 1'b0;
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
            samp_q   <= '0;
            raw_q    <= '0;
            avg_q    <= '0;
            hi_q     <= THR_HI_RST;
            lo_q     <= THR_LO_RST;
            acc_q    <= '0;
            n_q      <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            ot_q     <= ot_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
            samp_q   <= samp_d;
            raw_q    <= raw_d;
            avg_q    <= avg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dtr_start     = state_q == S_START;
    assign over_temp     = ot_q;
    assign sample_strobe = strobe_q;
    assign bus_ack       = ack_q;
    assign bus_rdata     = rdata_q;

endmodule
